gh_sum_pipe: RTL

Parametrised, pipelined successor to the bilateral-filter weight-sum block. It reduces N_IN unsigned Gaussian×histogram weights per beat through a registered adder tree, one register per level. It then accumulates the beat sums of a window that spans one or more beats, and presents a saturated total with a valid pulse. The block sits between the weight-generation array and the normaliser/divider. It replaces the combinational tree plus external hold register with a streaming, held-result datapath.

---
 rtl/gh_sum_pkg.sv | 29 ++
 rtl/gh_sum_pipe_add_stage.sv | 33 +++
 rtl/gh_sum_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gh_sum_pkg.sv
// Shared constants, tree-sizing helpers and accumulator state encoding
// for the Gaussian x histogram weight-sum pipeline.
package gh_sum_pkg;

  localparam int GH_N_IN  = 121;
  localparam int GH_IN_W  = 13;
  localparam int GH_ACC_W = 20;

  // Number of pairwise adder levels needed to reduce n weights to one.
  function automatic int levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Number of elements present at tree level k when starting from n.
  function automatic int nodes(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/gh_sum_pipe_add_stage.sv
// One registered level of the adder tree: adjacent pairs are summed,
// an unpaired last element is passed through zero-extended.
module gh_add_stage #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                           clk,
  input  logic [N*W-1:0]                 data,
  output logic [((N+1)/2)*(W+1)-1:0]     sums
);

  localparam int NO = (N + 1) / 2;

  logic [NO*(W+1)-1:0] sums_next;

  genvar gi;
  generate
    for (gi = 0; gi < NO; gi++) begin : g_node
      if (2*gi + 1 < N) begin : g_pair
        assign sums_next[gi*(W+1) +: W+1] =
          {1'b0, data[2*gi*W +: W]} + {1'b0, data[(2*gi+1)*W +: W]};
      end else begin : g_pass
        assign sums_next[gi*(W+1) +: W+1] = {1'b0, data[2*gi*W +: W]};
      end
    end
  endgenerate

  // Level register; data path needs no reset since validity travels separately.
  always_ff @(posedge clk) begin
    sums <= sums_next;
  end

endmodule

// File: rtl/gh_sum_pipe.sv
// Streaming weight-sum: registered adder tree per beat, then a windowed
// saturating accumulator that presents a held total with a valid pulse.
module gh_sum_pipe
  import gh_sum_pkg::*;
#(
  parameter int N_IN  = GH_N_IN,
  parameter int IN_W  = GH_IN_W,
  parameter int ACC_W = GH_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN*IN_W-1:0] gh_in,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_valid,
  output logic                 out_ovf
);

  localparam int LEVELS = levels(N_IN);
  localparam int TW     = IN_W + LEVELS;

  genvar gi;

  generate
    if (ACC_W < IN_W + LEVELS) begin : g_width_check
      $error("gh_sum_pipe: ACC_W too narrow for the full tree sum");
    end
  endgenerate

  // Adder tree: level 0 is the raw input, each later level is one registered stage.
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_tree
      localparam int NK = nodes(N_IN, gi);
      localparam int WK = IN_W + gi;
      logic [NK*WK-1:0] sums;
      if (gi == 0) begin : g_root
        assign sums = gh_in;
      end else begin : g_level
        gh_add_stage #(
          .N (nodes(N_IN, gi - 1)),
          .W (WK - 1)
        ) u_stage (
          .clk  (clk),
          .data (g_tree[gi-1].sums),
          .sums (sums)
        );
      end
    end
  endgenerate

  logic [TW-1:0] tree_out;
  assign tree_out = g_tree[LEVELS].sums;

  logic tvalid;
  logic tfirst;
  logic tlast;

  // Beat qualifiers ride alongside the tree so they line up with tree_out.
  generate
    if (LEVELS == 0) begin : g_nopipe
      assign tvalid = in_valid;
      assign tfirst = in_valid & in_first;
      assign tlast  = in_valid & in_last;
    end else begin : g_pipe
      logic [LEVELS-1:0] v_reg;
      logic [LEVELS-1:0] f_reg;
      logic [LEVELS-1:0] l_reg;
      // Shift register of valid/first/last; first/last are masked by valid on entry.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= '0;
          f_reg <= '0;
          l_reg <= '0;
        end else begin
          v_reg[0] <= in_valid;
          f_reg[0] <= in_valid & in_first;
          l_reg[0] <= in_valid & in_last;
          for (int i = 1; i < LEVELS; i++) begin
            v_reg[i] <= v_reg[i-1];
            f_reg[i] <= f_reg[i-1];
            l_reg[i] <= l_reg[i-1];
          end
        end
      end
      assign tvalid = v_reg[LEVELS-1];
      assign tfirst = f_reg[LEVELS-1];
      assign tlast  = l_reg[LEVELS-1];
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic               ovf_reg, ovf_next;
  logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
  logic               out_ovf_reg, out_ovf_next;
  logic               out_valid_reg, out_valid_next;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   tree_ext;

  assign tree_ext = ACC_W'(tree_out);

  // Accumulator FSM: open/extend the window, saturate on overflow, emit on last.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    out_sum_next   = out_sum_reg;
    out_ovf_next   = out_ovf_reg;
    out_valid_next = 1'b0;
    sum_wide       = {1'b0, acc_reg} + {1'b0, tree_ext};
    if (tvalid) begin
      if (tfirst || state_reg == ST_IDLE) begin
        // A beat without first while idle starts a window as well.
        acc_next = tree_ext;
        ovf_next = 1'b0;
      end else if (sum_wide[ACC_W]) begin
        acc_next = '1;
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_wide[ACC_W-1:0];
      end
      state_next = ST_ACCUM;
      if (tlast) begin
        out_sum_next   = acc_next;
        out_ovf_next   = ovf_next;
        out_valid_next = 1'b1;
        state_next     = ST_IDLE;
      end
    end
  end

  // Accumulator and held-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      out_sum_reg   <= out_sum_next;
      out_ovf_reg   <= out_ovf_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_valid = out_valid_reg;

endmodule
